// File: rtl/video_frame_writer_pkg.sv
// Shared types, widths and helpers for the video frame writer.
package video_frame_writer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_e;

  localparam int PIX_W  = 24;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 12;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Geometry counters stick at full scale instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/video_frame_writer_packer.sv
// Packs 24-bit pixels into 32-bit little-endian words (4 pixels -> 3 words),
// flushing held bytes zero-padded at line end.
module rgb24_to_32_packer
  import video_frame_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix,
  input  logic              flush,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]       phase_q, phase_d;
  logic [PIX_W-1:0] hold_q, hold_d;

  // Merge the incoming pixel with held bytes; held bytes stay right-aligned
  // with zeros above, so a flush word is simply the hold register padded.
  always_comb begin
    phase_d    = phase_q;
    hold_d     = hold_q;
    word_valid = 1'b0;
    word       = '0;
    if (clear) begin
      phase_d = '0;
      hold_d  = '0;
    end else if (pix_valid) begin
      phase_d = phase_q + 2'd1;
      unique case (phase_q)
        2'd0: begin
          hold_d = pix;
        end
        2'd1: begin
          word_valid = 1'b1;
          word       = {pix[7:0], hold_q};
          hold_d     = {8'h00, pix[23:8]};
        end
        2'd2: begin
          word_valid = 1'b1;
          word       = {pix[15:0], hold_q[15:0]};
          hold_d     = {16'h0000, pix[23:16]};
        end
        default: begin
          word_valid = 1'b1;
          word       = {pix, hold_q[7:0]};
          hold_d     = '0;
        end
      endcase
    end else if (flush) begin
      phase_d = '0;
      hold_d  = '0;
      if (phase_q != 2'd0) begin
        word_valid = 1'b1;
        word       = {8'h00, hold_q};
      end
    end
  end

  // Phase and holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      hold_q  <= '0;
    end else begin
      phase_q <= phase_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/video_frame_writer.sv
// Frame capture front end: vsync edge detect, capture FSM, geometry
// measurement, word addressing and FIFO overflow handling.
module video_frame_writer
  import video_frame_writer_pkg::*;
#(
  parameter int                ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter bit                VSYNC_POL = 1'b1
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              de,
  input  logic [PIX_W-1:0]  rgb_data,
  input  logic              capture_en,
  input  logic              wr_full,
  output logic              wr_en,
  output logic [WORD_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              frame_start,
  output logic              frame_done,
  output logic              overflow,
  output logic [CNT_W-1:0]  h_active,
  output logic [CNT_W-1:0]  v_active
);

  state_e              state_q, state_d;
  logic                vs_hist_q, vs_hist_d;
  logic                in_line_q, in_line_d;
  logic [ADDR_W-1:0]   nxt_addr_q, nxt_addr_d;
  logic [CNT_W-1:0]    pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]    line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0]    last_pix_q, last_pix_d;
  logic                wr_en_q, wr_en_d;
  logic [WORD_W-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                frame_start_q, frame_start_d;
  logic                frame_done_q, frame_done_d;
  logic                overflow_q, overflow_d;
  logic [CNT_W-1:0]    h_active_q, h_active_d;
  logic [CNT_W-1:0]    v_active_q, v_active_d;

  logic                vs_act, lead, capturing, pix_take, line_end;
  logic                pk_valid;
  logic [WORD_W-1:0]   pk_word;
  logic                unused_hsync;

  assign unused_hsync = hsync;

  // A leading edge ends all pixel work for that cycle: any residual is
  // discarded and a coincident line end is not counted.
  assign vs_act    = (vsync == VSYNC_POL);
  assign lead      = vs_act & ~vs_hist_q;
  assign capturing = (state_q == FRAME);
  assign pix_take  = capturing & de & ~lead;
  assign line_end  = capturing & in_line_q & ~de & ~lead;

  rgb24_to_32_packer u_packer (
    .clk        (pclk),
    .rst        (reset),
    .clear      (lead),
    .pix_valid  (pix_take),
    .pix        (rgb_data),
    .flush      (line_end),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  // Next-state: FSM, counters, addressing, write issue and geometry capture.
  always_comb begin
    state_d       = state_q;
    vs_hist_d     = vs_act;
    in_line_d     = in_line_q;
    nxt_addr_d    = nxt_addr_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    last_pix_d    = last_pix_q;
    wr_en_d       = 1'b0;
    wr_data_d     = wr_data_q;
    wr_addr_d     = wr_addr_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    overflow_d    = overflow_q;
    h_active_d    = h_active_q;
    v_active_d    = v_active_q;

    if (pix_take) begin
      in_line_d = 1'b1;
      pix_cnt_d = sat_inc(pix_cnt_q);
    end

    if (line_end) begin
      in_line_d  = 1'b0;
      pix_cnt_d  = '0;
      last_pix_d = pix_cnt_q;
      line_cnt_d = sat_inc(line_cnt_q);
    end

    // Address advances on drops too, keeping later words at their slots.
    if (pk_valid) begin
      nxt_addr_d = nxt_addr_q + 1'b1;
      if (wr_full) begin
        overflow_d = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        wr_data_d = pk_word;
        wr_addr_d = nxt_addr_q;
      end
    end

    if (lead) begin
      in_line_d = 1'b0;
      if (capturing) begin
        frame_done_d = 1'b1;
        h_active_d   = last_pix_q;
        v_active_d   = line_cnt_q;
      end
      if (capture_en) begin
        state_d       = FRAME;
        frame_start_d = 1'b1;
        nxt_addr_d    = BASE_ADDR;
        wr_addr_d     = BASE_ADDR;
        overflow_d    = 1'b0;
        pix_cnt_d     = '0;
        line_cnt_d    = '0;
        last_pix_d    = '0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      vs_hist_q     <= 1'b0;
      in_line_q     <= 1'b0;
      nxt_addr_q    <= BASE_ADDR;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      last_pix_q    <= '0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= '0;
      wr_addr_q     <= BASE_ADDR;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      h_active_q    <= '0;
      v_active_q    <= '0;
    end else begin
      state_q       <= state_d;
      vs_hist_q     <= vs_hist_d;
      in_line_q     <= in_line_d;
      nxt_addr_q    <= nxt_addr_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      last_pix_q    <= last_pix_d;
      wr_en_q       <= wr_en_d;
      wr_data_q     <= wr_data_d;
      wr_addr_q     <= wr_addr_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
      h_active_q    <= h_active_d;
      v_active_q    <= v_active_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_data     = wr_data_q;
  assign wr_addr     = wr_addr_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign h_active    = h_active_q;
  assign v_active    = v_active_q;

endmodule
